// File: rtl/parity_frame_tx.sv
// Serial transmitter for a 3-bit word plus its upstream even-parity bit.
// Frame: start(0), d[0], d[1], d[2], p, stop(1); each bit is held CLKS_PER_BIT clocks.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] d,
    input  logic       p,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       par_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [2:0]       d_q;
    logic             p_q;
    logic             bit_tc;
    logic             load;

    assign bit_tc = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign load   = (state == IDLE) && start;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tx         = 1'b1;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = START;
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (bit_tc) state_next = DATA;
            end
            DATA: begin
                tx   = d_q[idx];
                busy = 1'b1;
                if (bit_tc && idx == 2'd2) state_next = PARITY;
            end
            PARITY: begin
                // The captured parity goes out as-is, even when wrong, so downstream can flag it.
                tx   = p_q;
                busy = 1'b1;
                if (bit_tc) state_next = STOP;
            end
            STOP: begin
                busy = 1'b1;
                if (bit_tc) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            d_q     <= '0;
            p_q     <= 1'b0;
            par_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == STOP) && bit_tc;
            if (load) begin
                d_q     <= d;
                p_q     <= p;
                par_err <= (p != ^d);
                cnt     <= '0;
                idx     <= '0;
            end else if (state != IDLE) begin
                if (bit_tc) begin
                    cnt <= '0;
                    if (state == DATA) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; synchronous, active-low.
REQ-004 start  input  1  request to send one frame; sampled only in IDLE.
REQ-005 d  input  3  data word from the upstream even-parity generator (its input i).
REQ-006 p  input  1  even-parity bit from the upstream generator; intended value is ^d.
REQ-007 tx  output  1  serial line; idle level 1.
REQ-008 busy  output  1  high while a frame is in progress (START through STOP).
REQ-009 done  output  1  one-cycle pulse at frame completion.
REQ-010 par_err  output  1  high when the captured p did not equal ^d for the current/last frame.

Function
REQ-011 Frame order SHALL be: start bit 0, d[0], d[1], d[2], captured p, stop bit 1; total 6*CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE with start=1 at a rising edge SHALL capture d and p into internal registers, enter START, and set busy=1 and tx=0 from the next cycle.
REQ-014 Captured values SHALL be used for the whole frame; changes on d/p after capture SHALL NOT affect tx.
REQ-015 A bit-period counter of width $clog2(CLKS_PER_BIT+1) SHALL count 0..CLKS_PER_BIT-1 and advance the bit on the terminal count; it SHALL reset to 0 at every bit change.
REQ-016 DATA SHALL use a 2-bit index 0..2, sending d[index]; after index 2 completes -> PARITY.
REQ-017 PARITY SHALL drive the captured p unmodified (a wrong p is transmitted as-is so downstream checkers detect it).
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE; done SHALL be 1 in the first IDLE cycle only, and busy SHALL be 0 in that cycle.
REQ-019 start asserted while busy=1 SHALL be ignored (not queued).
REQ-020 start held high continuously SHALL begin a new frame on the cycle done is high (back-to-back frames, tx remains 1 for exactly one cycle between frames).
REQ-021 par_err SHALL update at capture to (p != ^d) and hold until the next capture.
REQ-022 With CLKS_PER_BIT=1 every state SHALL last exactly one cycle (frame = 6 cycles).

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, tx=1, busy=0, done=0, par_err=0, and clear counter, index and captured registers.
REQ-024 Reset mid-frame SHALL abort it immediately: tx=1 from the next cycle, no done pulse; start is ignored while rst_n=0.

Verification
REQ-025 Reset then idle 10 cycles -> tx=1, busy=0, done=0, par_err=0 throughout.
REQ-026 CLKS_PER_BIT=4, d=3'b101, p=0, start pulse -> tx sequence 0,1,0,1,0,1 each 4 cycles, done pulse 24 cycles after start accepted, par_err=0.
REQ-027 d=3'b001, p=0 (wrong parity) -> par_err=1 at capture, parity slot tx=0, frame otherwise normal.
REQ-028 start held high, d=3'b111, p=1 -> two back-to-back 24-cycle frames separated by one tx=1 cycle; done pulses once per frame.
REQ-029 start re-pulsed during DATA and d changed mid-frame -> no effect on tx; rst_n=0 during PARITY -> tx=1, busy=0 next cycle, no done.
REQ-030 CLKS_PER_BIT=1, d=3'b110, p=0 -> tx 0,0,1,1,0,1 on consecutive cycles, done on the 7th cycle.
